// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared constants and types for the mrv32 writeback path.
//   REG_ADDR_W - register address width
//   XLEN       - datapath width
//   NUM_REGS   - architectural register count (x0 included)
//   wb_sched_state_t - writeback arbiter priority state
package mrv32_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        WB_PRI,
        LL_PRI
    } wb_sched_state_t;

endpackage

// File: rtl/mrv32_scoreboard.sv
// mrv32_scoreboard: pending-register scoreboard for long-latency results.
//   clk, rst_n            - clock, synchronous active-low reset
//   set_en, set_rd        - mark set_rd pending on the next edge
//   clr_en, clr_rd        - retire clr_rd on the next edge (set wins on collision)
//   q_rs1/q_rs2/q_rd(_en) - issue-stage operand lookups
//   hazard                - any enabled operand is pending
//   idle                  - nothing pending
module mrv32_scoreboard
    import mrv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic                  q_rs1_en,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    input  logic                  q_rs2_en,
    input  logic [REG_ADDR_W-1:0] q_rd,
    input  logic                  q_rd_en,
    output logic                  hazard,
    output logic                  idle
);

    // x0 has no storage; pend_full pads it with a constant zero for lookups.
    logic [NUM_REGS-1:1] pend_q, pend_d;
    logic [NUM_REGS-1:0] pend_full;
    logic [NUM_REGS-1:0] pend_nxt;

    assign pend_full = {pend_q, 1'b0};

    always_comb begin
        pend_nxt = pend_full;
        if (clr_en && (clr_rd != '0)) begin
            pend_nxt[clr_rd] = 1'b0;
        end
        // Applied after the clear so a re-issue of the retiring register stays pending.
        if (set_en && (set_rd != '0)) begin
            pend_nxt[set_rd] = 1'b1;
        end
        pend_d = pend_nxt[NUM_REGS-1:1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Registered pend only: a retiring LL write is not bypassed to issue.
    assign hazard = rst_n & ((q_rs1_en & pend_full[q_rs1]) |
                             (q_rs2_en & pend_full[q_rs2]) |
                             (q_rd_en  & pend_full[q_rd]));
    assign idle   = ~rst_n | (pend_q == '0);

endmodule

// File: rtl/mrv32_wb_sched.sv
// mrv32_wb_sched: writeback scheduler in front of the register file write port.
//   clk, rst_n                 - clock, synchronous active-low reset
//   iss_valid, iss_rd          - LL op issue, claims iss_rd in the scoreboard
//   q_rs1/q_rs2/q_rd(_en)      - issue-stage operands checked for hazards
//   hazard, idle               - issue stall, no LL result outstanding
//   wb_valid/wb_rd/wb_data     - pipeline writeback request, wb_ready accept
//   ll_valid/ll_rd/ll_data     - long-latency writeback request, ll_ready accept
//   rf_wen/rf_addr/rf_wdata    - register file write port (zero latency)
module mrv32_wb_sched
    import mrv32_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic                  q_rs1_en,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    input  logic                  q_rs2_en,
    input  logic [REG_ADDR_W-1:0] q_rd,
    input  logic                  q_rd_en,
    output logic                  hazard,
    output logic                  idle,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  wb_ready,
    input  logic                  ll_valid,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]       ll_data,
    output logic                  ll_ready,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    wb_sched_state_t state_q, state_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            wb_xfer;
    logic            ll_xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WB_PRI;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wb_ready     = 1'b0;
        ll_ready     = 1'b0;
        wb_xfer      = 1'b0;
        ll_xfer      = 1'b0;
        rf_wen       = 1'b0;
        rf_addr      = '0;
        rf_wdata     = '0;
        if (rst_n) begin
            unique case (state_q)
                WB_PRI: begin
                    wb_ready = 1'b1;
                    ll_ready = ll_valid & ~wb_valid;
                    if (ll_valid && !ll_ready) begin
                        if (starve_cnt_q == STARVE_LAST) begin
                            state_d      = LL_PRI;
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != 4'hF) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
                LL_PRI: begin
                    ll_ready     = ll_valid;
                    starve_cnt_d = '0;
                    // Either LL transfers now, or ll_valid dropped (protocol
                    // violation): both return priority to the pipeline.
                    state_d      = WB_PRI;
                end
            endcase
            wb_xfer = wb_valid & wb_ready;
            ll_xfer = ll_valid & ll_ready;
            if (wb_xfer) begin
                rf_wen   = (wb_rd != '0);
                rf_addr  = wb_rd;
                rf_wdata = wb_data;
            end else if (ll_xfer) begin
                rf_wen   = (ll_rd != '0);
                rf_addr  = ll_rd;
                rf_wdata = ll_data;
            end
        end
    end

    mrv32_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_rd   (iss_rd),
        .clr_en   (ll_xfer),
        .clr_rd   (ll_rd),
        .q_rs1    (q_rs1),
        .q_rs1_en (q_rs1_en),
        .q_rs2    (q_rs2),
        .q_rs2_en (q_rs2_en),
        .q_rd     (q_rd),
        .q_rd_en  (q_rd_en),
        .hazard   (hazard),
        .idle     (idle)
    );

endmodule
